// File: rtl/reg_wb_file_if.sv
// Bus between decode/execute/load paths and the write-back register file.
// Handshake: a load transfers on a rising edge where LD_VALID && LD_READY;
// the load source must hold LD_REG/LD_DATA stable while LD_VALID is high.
// The execute path has no ready: EX_VALID is accepted on every edge.
interface reg_wb_file_if;
  logic        ISSUE_VALID;
  logic [2:0]  ISSUE_REG;
  logic        EX_VALID;
  logic [2:0]  EX_REG;
  logic [15:0] EX_DATA;
  logic [1:0]  EX_MODE;
  logic        LD_VALID;
  logic        LD_READY;
  logic [2:0]  LD_REG;
  logic [15:0] LD_DATA;
  logic [15:0] REG_0;
  logic [15:0] REG_1;
  logic [15:0] REG_2;
  logic [15:0] REG_3;
  logic [15:0] REG_4;
  logic [15:0] REG_5;
  logic [15:0] REG_6;
  logic [15:0] REG_7;
  logic [7:0]  BUSY;
  logic        ERR;

  modport master (
    output ISSUE_VALID, ISSUE_REG, EX_VALID, EX_REG, EX_DATA, EX_MODE,
           LD_VALID, LD_REG, LD_DATA,
    input  LD_READY, REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7,
           BUSY, ERR
  );

  modport slave (
    input  ISSUE_VALID, ISSUE_REG, EX_VALID, EX_REG, EX_DATA, EX_MODE,
           LD_VALID, LD_REG, LD_DATA,
    output LD_READY, REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7,
           BUSY, ERR
  );
endinterface

// File: rtl/reg_wb_file.sv
// Write-back stage and 8 x 16-bit architectural register file.
// One commit per cycle: execute first, then a parked load, then a direct
// load. A one-entry holding buffer parks a load that loses to execute.
module reg_wb_file (
  input  logic          CLK_WB,
  input  logic          N_RST,
  reg_wb_file_if.slave  bus
);

  logic [15:0] rf_q [8];
  logic [7:0]  busy_q;
  logic [7:0]  busy_d;
  logic        err_q;
  logic        hold_full_q;
  logic        hold_full_d;
  logic [2:0]  hold_reg_q;
  logic [15:0] hold_data_q;
  logic        ld_ready_q;
  logic        ld_xfer;

  logic        c_valid;
  logic [2:0]  c_reg;
  logic [15:0] c_data;
  logic [1:0]  c_mode;
  logic [15:0] c_old;
  logic [15:0] c_wdata;

  // LD_READY is registered and always equals the inverse of the buffer state.
  assign ld_xfer = bus.LD_VALID & ld_ready_q;

  // Pick the single result that commits this cycle.
  always_comb begin
    c_valid = 1'b0;
    c_reg   = 3'd0;
    c_data  = 16'h0000;
    c_mode  = 2'b00;
    if (bus.EX_VALID) begin
      c_valid = 1'b1;
      c_reg   = bus.EX_REG;
      c_data  = bus.EX_DATA;
      c_mode  = bus.EX_MODE;
    end else if (hold_full_q) begin
      c_valid = 1'b1;
      c_reg   = hold_reg_q;
      c_data  = hold_data_q;
    end else if (ld_xfer) begin
      c_valid = 1'b1;
      c_reg   = bus.LD_REG;
      c_data  = bus.LD_DATA;
    end
  end

  // Merge the committed data into the target register by write mode.
  always_comb begin
    c_old   = rf_q[c_reg];
    c_wdata = c_old;
    case (c_mode)
      2'b00:   c_wdata = c_data;
      2'b01:   c_wdata = {c_old[15:8], c_data[7:0]};
      2'b10:   c_wdata = {c_data[7:0], c_old[7:0]};
      default: c_wdata = c_old;
    endcase
  end

  // Scoreboard and buffer next state; an issue in the same cycle as a
  // commit to the same register wins, since the newer write is outstanding.
  always_comb begin
    busy_d = busy_q;
    if (c_valid) busy_d[c_reg] = 1'b0;
    if (bus.ISSUE_VALID) busy_d[bus.ISSUE_REG] = 1'b1;
    hold_full_d = hold_full_q;
    if (bus.EX_VALID && ld_xfer) hold_full_d = 1'b1;
    else if (!bus.EX_VALID && hold_full_q) hold_full_d = 1'b0;
  end

  // State update; reset discards any parked load and all pending state.
  always_ff @(posedge CLK_WB) begin
    if (!N_RST) begin
      for (int i = 0; i < 8; i++) rf_q[i] <= 16'h0000;
      busy_q      <= 8'h00;
      err_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_reg_q  <= 3'd0;
      hold_data_q <= 16'h0000;
      ld_ready_q  <= 1'b1;
    end else begin
      if (c_valid) rf_q[c_reg] <= c_wdata;
      if (c_valid && !busy_q[c_reg]) err_q <= 1'b1;
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
      ld_ready_q  <= ~hold_full_d;
      if (bus.EX_VALID && ld_xfer) begin
        hold_reg_q  <= bus.LD_REG;
        hold_data_q <= bus.LD_DATA;
      end
    end
  end

  assign bus.LD_READY = ld_ready_q;
  assign bus.BUSY     = busy_q;
  assign bus.ERR      = err_q;
  assign bus.REG_0    = rf_q[0];
  assign bus.REG_1    = rf_q[1];
  assign bus.REG_2    = rf_q[2];
  assign bus.REG_3    = rf_q[3];
  assign bus.REG_4    = rf_q[4];
  assign bus.REG_5    = rf_q[5];
  assign bus.REG_6    = rf_q[6];
  assign bus.REG_7    = rf_q[7];

endmodule

// File: tb/tb_reg_wb_file.sv
// Bench for reg_wb_file: directed steps followed by a random phase, all
// checked against a queue-based behavioural model of the write-back rules.
module tb_reg_wb_file;

  logic clk;
  logic n_rst;
  int   total;
  int   bad;

  reg_wb_file_if bus ();

  reg_wb_file dut (
    .CLK_WB (clk),
    .N_RST  (n_rst),
    .bus    (bus)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register array, pending-write set, sticky error and
  // a FIFO of loads accepted but not yet written.
  typedef struct {
    logic [2:0]  r;
    logic [15:0] d;
  } ld_t;

  logic [15:0] m_reg [8];
  logic [7:0]  m_busy;
  logic        m_err;
  ld_t         pend_q [$];

  logic [15:0] obs_reg [8];
  always_comb begin
    obs_reg[0] = bus.REG_0;
    obs_reg[1] = bus.REG_1;
    obs_reg[2] = bus.REG_2;
    obs_reg[3] = bus.REG_3;
    obs_reg[4] = bus.REG_4;
    obs_reg[5] = bus.REG_5;
    obs_reg[6] = bus.REG_6;
    obs_reg[7] = bus.REG_7;
  end

  task automatic m_write(input logic [2:0] r, input logic [15:0] d, input logic [1:0] mode);
    if (m_busy[r] == 1'b0) m_err = 1'b1;
    m_busy[r] = 1'b0;
    if (mode == 2'b00) m_reg[r] = d;
    else if (mode == 2'b01) m_reg[r] = (m_reg[r] & 16'hFF00) | {8'h00, d[7:0]};
    else if (mode == 2'b10) m_reg[r] = (m_reg[r] & 16'h00FF) | ({8'h00, d[7:0]} << 8);
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_edge();
    bit   ld_acc;
    ld_t  e;
    if (!n_rst) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_busy = 8'h00;
      m_err  = 1'b0;
      pend_q.delete();
      return;
    end
    ld_acc = bus.LD_VALID && (pend_q.size() == 0);
    e.r = bus.LD_REG;
    e.d = bus.LD_DATA;
    if (bus.EX_VALID) begin
      m_write(bus.EX_REG, bus.EX_DATA, bus.EX_MODE);
      if (ld_acc) pend_q.push_back(e);
    end else if (pend_q.size() != 0) begin
      e = pend_q.pop_front();
      m_write(e.r, e.d, 2'b00);
    end else if (ld_acc) begin
      m_write(e.r, e.d, 2'b00);
    end
    if (bus.ISSUE_VALID) m_busy[bus.ISSUE_REG] = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) chk($sformatf("REG_%0d", i), obs_reg[i], m_reg[i]);
    chk("BUSY", {8'h00, bus.BUSY}, {8'h00, m_busy});
    chk("ERR", {15'h0, bus.ERR}, {15'h0, m_err});
    chk("LD_READY", {15'h0, bus.LD_READY}, {15'h0, pend_q.size() == 0});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.ISSUE_VALID = 1'b0;
    bus.ISSUE_REG   = 3'd0;
    bus.EX_VALID    = 1'b0;
    bus.EX_REG      = 3'd0;
    bus.EX_DATA     = 16'h0000;
    bus.EX_MODE     = 2'b00;
    bus.LD_VALID    = 1'b0;
    bus.LD_REG      = 3'd0;
    bus.LD_DATA     = 16'h0000;
  endtask

  task automatic issue(input logic [2:0] r);
    bus.ISSUE_VALID = 1'b1;
    bus.ISSUE_REG   = r;
  endtask

  task automatic ex(input logic [2:0] r, input logic [15:0] d, input logic [1:0] mode);
    bus.EX_VALID = 1'b1;
    bus.EX_REG   = r;
    bus.EX_DATA  = d;
    bus.EX_MODE  = mode;
  endtask

  task automatic ld(input logic [2:0] r, input logic [15:0] d);
    bus.LD_VALID = 1'b1;
    bus.LD_REG   = r;
    bus.LD_DATA  = d;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_busy = 8'h00;
    m_err  = 1'b0;
    idle();

    // Reset, dirty some registers, reset again.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    ex(3'd1, 16'hBEEF, 2'b00); step();
    ex(3'd6, 16'h5A5A, 2'b00); issue(3'd2); step();
    idle(); ex(3'd0, 16'h1111, 2'b00); ld(3'd4, 16'h4444); step();
    idle();
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    chk("rst_reg1", bus.REG_1, 16'h0000);
    chk("rst_busy", {8'h00, bus.BUSY}, 16'h0000);
    chk("rst_err", {15'h0, bus.ERR}, 16'h0000);
    chk("rst_ready", {15'h0, bus.LD_READY}, 16'h0001);
    idle(); step();
    chk("rst_no_stale_load", bus.REG_4, 16'h0000);

    // Partial writes to R3.
    issue(3'd3); step();
    idle(); ex(3'd3, 16'h1234, 2'b00); step();
    chk("full_r3", bus.REG_3, 16'h1234);
    chk("full_busy3", {15'h0, bus.BUSY[3]}, 16'h0000);
    idle(); issue(3'd3); step();
    idle(); ex(3'd3, 16'h00AB, 2'b01); step();
    chk("ldl_r3", bus.REG_3, 16'h12AB);
    idle(); issue(3'd3); step();
    idle(); ex(3'd3, 16'h00CD, 2'b10); step();
    chk("ldh_r3", bus.REG_3, 16'hCDAB);

    // Collision: execute to R1 and load to R2 on the same edge.
    idle(); issue(3'd1); step();
    idle(); issue(3'd2); step();
    idle(); ex(3'd1, 16'h1111, 2'b00); ld(3'd2, 16'h2222); step();
    chk("col_r1", bus.REG_1, 16'h1111);
    chk("col_ready0", {15'h0, bus.LD_READY}, 16'h0000);
    chk("col_busy", {8'h00, bus.BUSY}, 16'h0004);
    idle(); step();
    chk("col_r2", bus.REG_2, 16'h2222);
    chk("col_ready1", {15'h0, bus.LD_READY}, 16'h0001);
    chk("col_busy0", {8'h00, bus.BUSY}, 16'h0000);

    // Starvation: parked load to R6 under five cycles of execute traffic.
    idle(); issue(3'd0); step();
    idle(); issue(3'd6); step();
    for (int k = 0; k < 5; k++) begin
      idle(); issue(3'd0); ex(3'd0, 16'h0A00 + 16'(k), 2'b00);
      if (k == 0) ld(3'd6, 16'h6666);
      step();
      chk("starve_r6", bus.REG_6, 16'h0000);
      chk("starve_ready", {15'h0, bus.LD_READY}, 16'h0000);
    end
    idle(); step();
    chk("starve_commit", bus.REG_6, 16'h6666);
    idle(); ex(3'd0, 16'h0000, 2'b11); step();

    // Scoreboard race: issue and commit to R5 on the same edge.
    idle(); issue(3'd5); step();
    idle(); issue(3'd5); ex(3'd5, 16'h5555, 2'b00); step();
    chk("race_r5", bus.REG_5, 16'h5555);
    chk("race_busy5", {15'h0, bus.BUSY[5]}, 16'h0001);
    chk("race_err", {15'h0, bus.ERR}, 16'h0000);
    idle(); ex(3'd5, 16'h0055, 2'b01); step();

    // Error on a non-busy commit, then retire-only mode on busy R4.
    idle(); ex(3'd7, 16'h7777, 2'b00); step();
    chk("err_set", {15'h0, bus.ERR}, 16'h0001);
    idle(); step();
    chk("err_sticky", {15'h0, bus.ERR}, 16'h0001);
    idle(); issue(3'd4); step();
    idle(); ex(3'd4, 16'hFFFF, 2'b11); step();
    chk("nowrite_r4", bus.REG_4, 16'h0000);
    chk("nowrite_busy4", {15'h0, bus.BUSY[4]}, 16'h0000);

    // Reset with a load parked in the buffer.
    idle(); ex(3'd1, 16'h0101, 2'b00); ld(3'd2, 16'hDEAD); step();
    idle(); n_rst = 1'b0; step();
    n_rst = 1'b1; step();
    chk("rst_drop_load", bus.REG_2, 16'h0000);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      idle();
      if ($urandom_range(0, 1) == 1) issue(3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0)
        ex(3'($urandom_range(0, 7)), 16'($urandom), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) ld(3'($urandom_range(0, 7)), 16'($urandom));
      n_rst = ($urandom_range(0, 99) != 0);
      step();
    end
    n_rst = 1'b1;
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_wb_file.md
# reg_wb_file

Write-back stage and architectural register file for the 16-bit, 8-register core. It holds R0–R7 and drives them straight into the decode-stage register read. It accepts results from two sources: the ALU/execute stage and the memory-load return path. Only one result commits per cycle, so a 1-entry holding buffer parks a load that loses arbitration. A per-register pending scoreboard lets decode stall on registers with an outstanding write.

## Interface
Parameters
- none (fixed 8 × 16-bit register file)

Ports
- CLK_WB  in  1  stage clock; all state updates on rising edge
- N_RST  in  1  synchronous reset, active-low; sampled on rising edge of CLK_WB
- ISSUE_VALID  in  1  decode issues an instruction that will write ISSUE_REG
- ISSUE_REG  in  3  destination register number of the issued instruction
- EX_VALID  in  1  execute result present
- EX_REG  in  3  execute destination register
- EX_DATA  in  16  execute result
- EX_MODE  in  2  00 full word; 01 low byte (LDL); 10 high byte (LDH); 11 no write, retire only
- LD_VALID  in  1  load data present
- LD_READY  out  1  load path may present data
- LD_REG  in  3  load destination register
- LD_DATA  in  16  load data (always full word)
- REG_0 … REG_7  out  16 each  current register contents, registered
- BUSY  out  8  bit n = 1: Rn has an outstanding write
- ERR  out  1  sticky: a commit hit a register whose BUSY bit was 0

## Operation
- Reset (N_RST = 0 at a clock edge) has these effects:
  - REG_0..REG_7 = 16'h0000, BUSY = 8'h00, ERR = 0.
  - The holding buffer is emptied and LD_READY = 1.
  - Reset wins over every other input in that cycle. Reset mid-operation discards the held load and all pending state.
- Execute path: EX_VALID is always accepted; there is no ready signal. Execute has absolute priority.
- Load handshake: a load transfers when LD_VALID && LD_READY at a clock edge. LD_READY = !HOLD_FULL and is registered.
- Commit selection each cycle, in priority order:
  1. EX_VALID: commit the execute result. An incoming load, if transferred, goes into the holding buffer.
  2. Else, if the holding buffer is full: commit the held load and empty the buffer. A load transferring in the same cycle is impossible because LD_READY = 0.
  3. Else, if a load transfers: commit it directly, with no buffering.
- Write modes:
  - Full: Rn ← DATA.
  - Low byte: Rn[7:0] ← DATA[7:0], Rn[15:8] unchanged.
  - High byte: Rn[15:8] ← DATA[7:0], Rn[7:0] unchanged.
  - 11: no register change.
  - Loads always use full mode.
- Scoreboard:
  - ISSUE_VALID sets BUSY[ISSUE_REG].
  - A commit to register n clears BUSY[n].
  - Issue and commit to the same register in the same cycle: BUSY stays 1, because the newer write is outstanding.
- ERR is set when a commit targets a register whose BUSY bit was 0 before that edge. The write still happens. ERR clears only on reset.

## Timing
- Commit latency: 0 cycles. Data presented at edge k is visible on REG_n after edge k and is sampled by decode at its next edge. There is no bypass from EX_DATA/LD_DATA to REG_n.
- A held load commits on the first edge where EX_VALID = 0. Worst case it waits indefinitely under continuous execute traffic.
- LD_READY falls on the edge that fills the buffer and rises on the edge that drains it. The next load can therefore transfer one cycle after the drain.
- BUSY updates on the same edge as the commit or issue.
- Back-to-back commits to the same register on consecutive edges are each applied in order. Between an execute commit and a load commit in the same cycle, execute is applied first; the load follows on a later edge.

## Test plan
- Reset: drive non-zero registers, then hold N_RST = 0 for one edge. Required: all REG_n = 0000, BUSY = 00, ERR = 0, LD_READY = 1.
- Partial writes:
  - Issue R3, then execute full write R3 = 0x1234 → REG_3 = 1234, BUSY[3] = 0.
  - Issue, then LDL 0x00AB to R3 → 12AB.
  - Issue, then LDH 0x00CD to R3 → CDAB.
- Collision: issue R1 and R2; at the same edge drive EX R1 = 0x1111 and LD R2 = 0x2222.
  - Next edge: REG_1 = 1111, LD_READY = 0, BUSY = 04.
  - Following edge with EX idle: REG_2 = 2222, LD_READY = 1, BUSY = 00.
- Starvation: hold a buffered load while EX_VALID = 1 for 5 cycles → REG_n for the load is unchanged and LD_READY = 0 throughout. It commits on the first idle edge.
- Scoreboard race: ISSUE_VALID with R5 in the same cycle as an EX commit to R5 → REG_5 is updated, BUSY[5] = 1, ERR = 0.
- Error and no-write mode:
  - Commit to R7 with BUSY[7] = 0 → ERR = 1 and it stays 1.
  - EX_MODE = 11 on a busy R4 → REG_4 unchanged, BUSY[4] = 0.
